// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the main-bus round-robin arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANTED,
        ARB_BUSY,
        ARB_RELEASE
    } arb_state_t;

    localparam int MAX_REQ               = 8;
    localparam int DEFAULT_GRANT_TIMEOUT = 16;
    localparam int DEFAULT_TURNAROUND    = 1;

    // Index of the set bit; OR-accumulating keeps it a plain encoder with no priority chain.
    function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate requests so the slot after last_id
// sits at bit 0, priority-encode the lowest set bit, then undo the rotation.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_id_i,
    output logic               winner_valid_o,
    output logic [ID_W-1:0]    winner_id_o,
    output logic [NUM_REQ-1:0] winner_onehot_o
);

    logic [ID_W-1:0]    start;
    logic [ID_W-1:0]    offset;
    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;

    always_comb begin
        start = (last_id_i == ID_W'(NUM_REQ - 1)) ? '0 : last_id_i + ID_W'(1);
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = req_i[ID_W'((int'(start) + i) % NUM_REQ)];
        end
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, start} + {1'b0, offset};
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            winner_id_o = ID_W'(sum - (ID_W + 1)'(NUM_REQ));
        end else begin
            winner_id_o = sum[ID_W-1:0];
        end
        winner_valid_o  = |req_i;
        winner_onehot_o = winner_valid_o ? (NUM_REQ'(1) << winner_id_o) : '0;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared main memory bus, with a watchdog
// that revokes grants the client never starts using.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = $clog2(NUM_REQ),
    parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT,
    parameter int TURNAROUND    = DEFAULT_TURNAROUND
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_cyc,
    input  logic [NUM_REQ-1:0] req_busy,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               timeout_err,
    output logic [ID_W-1:0]    err_id
);

    localparam int WD_W = $clog2(GRANT_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(GRANT_TIMEOUT - 1);
    localparam logic [1:0]      GAP_LAST = (TURNAROUND == 0) ? 2'd0 : 2'(TURNAROUND - 1);

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [1:0]         gap_q, gap_d;
    logic               terr_q, terr_d;
    logic [ID_W-1:0]    err_id_q, err_id_d;

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [NUM_REQ-1:0] win_onehot;
    logic               arbitrate;
    logic               release_now;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_i           (req_cyc),
        .last_id_i       (last_id_q),
        .winner_valid_o  (win_valid),
        .winner_id_o     (win_id),
        .winner_onehot_o (win_onehot)
    );

    // While owned, last_id_q is the owner's index; activity from other clients is never looked at.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_id_d   = last_id_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        terr_d      = 1'b0;
        err_id_d    = err_id_q;
        arbitrate   = 1'b0;
        release_now = 1'b0;

        case (state_q)
            ARB_IDLE: arbitrate = 1'b1;
            ARB_GRANTED: begin
                if (req_busy[last_id_q]) begin
                    state_d = ARB_BUSY;
                end else if (!req_cyc[last_id_q]) begin
                    release_now = 1'b1;
                end else if (wd_q == WD_LAST) begin
                    terr_d      = 1'b1;
                    err_id_d    = last_id_q;
                    release_now = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ARB_BUSY: begin
                if (!req_busy[last_id_q]) begin
                    release_now = 1'b1;
                end
            end
            ARB_RELEASE: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // With no turnaround the next owner is picked on the releasing edge itself.
        if (release_now) begin
            grant_d = '0;
            gap_d   = '0;
            if (TURNAROUND == 0) begin
                state_d   = ARB_IDLE;
                arbitrate = 1'b1;
            end else begin
                state_d = ARB_RELEASE;
            end
        end

        if (arbitrate && win_valid) begin
            grant_d   = win_onehot;
            last_id_d = win_id;
            wd_d      = '0;
            state_d   = ARB_GRANTED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            last_id_q <= ID_W'(NUM_REQ - 1);
            wd_q      <= '0;
            gap_q     <= '0;
            terr_q    <= 1'b0;
            err_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_id_q <= last_id_d;
            wd_q      <= wd_d;
            gap_q     <= gap_d;
            terr_q    <= terr_d;
            err_id_q  <= err_id_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = ID_W'(onehot_to_idx(MAX_REQ'(grant_q)));
    assign timeout_err = terr_q;
    assign err_id      = err_id_q;

endmodule
